// File: rtl/layer1_input_stage.sv
// Two-entry skid buffer feeding the layer0 activation vector into the layer1 neuron LUTs.
// Latency: 1 cycle from an accepted input frame to out_valid/out_data.
// Backpressure: in_ready is registered and drops only when both entries are occupied; it never sees out_ready combinationally.
//
// Ports:
//   clk, rst_n          single clock; asynchronous active-low reset
//   flush               synchronous discard of both buffered frames (counters keep counting)
//   in_data/in_valid/in_ready      upstream valid-ready handshake
//   out_data/out_valid/out_ready   downstream valid-ready handshake; out_data is the main register
//   frame_cnt, stall_cnt           delivered-frame and stalled-cycle counters (wrap at 2^CNT_W)
//
// Optional feature: define LAYER1_INPUT_STAGE_STATS_EN to build the counters;
// without it both counter outputs are tied to zero and no counter logic exists.

module layer1_input_stage #(
    parameter int IN_W  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IN_W-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // Occupancy: number of frames currently held (main register first, skid second).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IN_W-1:0] main_q;
    logic [IN_W-1:0] main_d;
    logic [IN_W-1:0] skid_q;
    logic [IN_W-1:0] skid_d;
    logic            in_ready_q;
    logic            in_xfer;
    logic            out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;

    // in_ready_q is already low in FULL, so an input transfer can only
    // happen in EMPTY or ONE; the FULL branch below relies on this.
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    // Next-state and datapath steering.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Both entries and any frame offered this cycle are dropped.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        // Consumer takes main while a new frame replaces it.
                        state_d = ONE;
                        main_d  = in_data;
                    end else if (in_xfer) begin
                        // Main is stalled, so the new frame parks in skid.
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, data and the registered ready. in_ready_q is derived from the
    // next state so it is exact on every cycle without a combinational path
    // from out_ready; it stays low during reset and rises on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

`ifdef LAYER1_INPUT_STAGE_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Both counters wrap naturally at 2^CNT_W and ignore flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_xfer) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign frame_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_layer1_input_stage.sv
// Bench for layer1_input_stage: directed scenarios followed by a long random
// valid/ready run, all checked against a queue-based reference model.
// Counter expectations follow whether LAYER1_INPUT_STAGE_STATS_EN is defined.

module tb_layer1_input_stage;

    localparam int IN_W  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] stall_cnt;

    layer1_input_stage #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two frames plus plain counters.
    logic [IN_W-1:0] q[$];
    bit              rdy_ok = 1'b0;   // in_ready is low until the first edge after reset
    int              m_fcnt = 0;
    int              m_scnt = 0;
    int              m_deliv = 0;
    bit              prev_stall = 1'b0;
    logic [IN_W-1:0] held = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int v);
`ifdef LAYER1_INPUT_STAGE_STATS_EN
        return 64'(v % (1 << CNT_W));
`else
        return 64'(v * 0);
`endif
    endfunction

    // Check the outputs against the model, apply one cycle of inputs,
    // clock once, then advance the model by the same rules.
    task automatic step(input bit v, input logic [IN_W-1:0] d, input bit r, input bit f);
        bit m_rdy;
        bit m_vld;
        bit in_x;
        bit out_x;
        m_rdy = rdy_ok && (q.size() < 2);
        m_vld = (q.size() > 0);
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_vld));
        if (m_vld) chk("out_data", out_data, q[0]);
        if (prev_stall && m_vld) chk("stall_hold", out_data, held);
        chk("frame_cnt", 64'(frame_cnt), exp_cnt(m_fcnt));
        chk("stall_cnt", 64'(stall_cnt), exp_cnt(m_scnt));

        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        in_x  = v && m_rdy;
        out_x = m_vld && r;
        prev_stall = m_vld && !r && !f;
        if (m_vld) held = q[0];

        @(posedge clk);
        #1;

        if (out_x) m_fcnt++;
        if (m_vld && !r) m_scnt++;
        if (f) begin
            q.delete();
        end else begin
            if (out_x) begin
                void'(q.pop_front());
                m_deliv++;
            end
            if (in_x) q.push_back(d);
        end
        rdy_ok = 1'b1;
    endtask

    // Assert reset away from the clock edge and check its immediate effect.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        rdy_ok = 1'b0;
        m_fcnt = 0;
        m_scnt = 0;
        prev_stall = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cycles;

        // Power-on reset.
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2;
        async_reset();
        step(0, 64'hDEAD, 0, 0);            // in_ready rises on this edge
        chk("ready_after_rel", 64'(in_ready), 64'd1);

        // Counter scenario: 17 deliveries then 3 stalled cycles.
        for (int i = 0; i < 17; i++) step(1, 64'(i + 100), 1, 0);
        step(0, 64'h0, 1, 0);
        step(1, 64'h99, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 64'h0, 0, 0);
        chk("frame_cnt_wrap", 64'(frame_cnt), exp_cnt(17));
        chk("stall_cnt_3", 64'(stall_cnt), exp_cnt(3));
        step(0, 64'h0, 1, 0);

        // Streaming: frames 1..5 back to back with latency 1.
        for (int i = 1; i <= 5; i++) begin
            step(1, 64'(i), 1, 0);
            chk("stream_data", out_data, 64'(i));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        step(0, 64'h0, 1, 0);
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure into FULL, then drain in order.
        step(1, 64'hA, 0, 0);
        step(1, 64'hB, 0, 0);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_hold_a", out_data, 64'hA);
        step(1, 64'hEE, 0, 0);               // refused while FULL
        chk("full_still_a", out_data, 64'hA);
        step(0, 64'h0, 1, 0);
        chk("drain_b", out_data, 64'hB);
        chk("drain_ready", 64'(in_ready), 64'd1);
        step(0, 64'h0, 1, 0);
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Flush from FULL.
        step(1, 64'h1, 0, 0);
        step(1, 64'h2, 0, 0);
        step(0, 64'h0, 0, 1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        step(1, 64'hC, 1, 0);
        chk("after_flush_c", out_data, 64'hC);
        chk("after_flush_v", 64'(out_valid), 64'd1);
        // Frame offered in the flush cycle is discarded as well.
        step(1, 64'h77, 0, 1);
        chk("flush_drops_in", 64'(out_valid), 64'd0);
        step(0, 64'h0, 1, 0);

        // Reset while FULL.
        step(1, 64'h3, 0, 0);
        step(1, 64'h4, 0, 0);
        async_reset();
        step(1, 64'h55, 1, 0);               // not accepted: in_ready still low
        step(1, 64'hD, 1, 0);
        chk("post_rst_first", out_data, 64'hD);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        step(0, 64'h0, 1, 0);

        // Random traffic: 50% in_valid and out_ready, random data always.
        cycles = 0;
        while (m_deliv < 10000 && cycles < 60000) begin
            logic [IN_W-1:0] d;
            d = {$urandom, $urandom};
            step(1'($urandom_range(1)), d, 1'($urandom_range(1)), 0);
            cycles++;
        end
        chk("rand_budget", 64'(m_deliv >= 10000), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 64'h0, 1, 0);
        chk("rand_drained", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
